// File: rtl/alu_result_pkg.sv
// Shared constants for the ALU result collector: register offsets, STATUS bits, entry layout.
// Define ALU_RESULT_TIMESTAMP_EN to widen entries to 32 bits with a cycle stamp.
package alu_result_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_TSNOW  = 2'd3;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_COUNT_W   = 6;
    localparam int ST_EMPTY     = 8;
    localparam int ST_FULL      = 9;
    localparam int ST_OVF       = 10;
    localparam int ST_UDF       = 11;

    localparam int OUT1_LSB = 0;
    localparam int OUT2_LSB = 4;
    localparam int C1_BIT   = 8;
    localparam int C2_BIT   = 9;
    localparam int X_LSB    = 10;
    localparam int Y_BIT    = 14;

`ifdef ALU_RESULT_TIMESTAMP_EN
    localparam int TS_LSB  = 16;
    localparam int ENTRY_W = 32;
`else
    localparam int ENTRY_W = 15;
`endif

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with flush; read data is the head entry (0 when empty).
module result_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 15,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_result_collector.sv
// Captures dual-ALU/XOR result bundles into a FIFO and serves them over a Wishbone slave.
// Optional ALU_RESULT_TIMESTAMP_EN stamps entries with a 16-bit cycle counter and adds TSNOW.
module alu_result_collector #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          IRQ_THRESH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cap_i,
    input  logic [1:0]  active_i,
    input  logic [3:0]  alu_out1_i,
    input  logic [3:0]  alu_out2_i,
    input  logic        carry1_i,
    input  logic        carry2_i,
    input  logic [3:0]  x_i,
    input  logic        y_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);
    import alu_result_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH = CW'(IRQ_THRESH);

    logic               ack_q, irq_q, ovf_q, udf_q;
    logic               ack_d, irq_d, ovf_d, udf_d;
    logic [31:0]        dat_q, dat_d, status;
    logic [1:0]         off;
    logic               req, rd, wr_ctrl, push, pop, flush, clr;
    logic [ENTRY_W-1:0] entry, head;
    logic               full, empty;
    logic [CW-1:0]      count;
    logic               unused_bits;

    assign off     = wbs_adr_i[3:2];
    assign req     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == ADDR_BASE[31:4]) && !ack_q;
    assign rd      = req && !wbs_we_i;
    assign wr_ctrl = req && wbs_we_i && (off == REG_CTRL) && wbs_sel_i[0];
    // Pop is taken on the request cycle so a held strobe cannot pop twice.
    assign pop     = rd && (off == REG_DATA);
    assign flush   = wr_ctrl && wbs_dat_i[1];
    assign clr     = wr_ctrl && wbs_dat_i[0];
    assign push    = cap_i && (active_i == 2'b00);

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:2]};

`ifdef ALU_RESULT_TIMESTAMP_EN
    logic [15:0] ts_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) ts_q <= '0;
        else             ts_q <= ts_q + 1'b1;
    end
`endif

    always_comb begin
        entry = '0;
        entry[OUT1_LSB +: 4] = alu_out1_i;
        entry[OUT2_LSB +: 4] = alu_out2_i;
        entry[C1_BIT]        = carry1_i;
        entry[C2_BIT]        = carry2_i;
        entry[X_LSB +: 4]    = x_i;
        entry[Y_BIT]         = y_i;
`ifdef ALU_RESULT_TIMESTAMP_EN
        entry[TS_LSB +: 16]  = ts_q;
`endif
    end

    result_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        status = '0;
        status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf_q;
        status[ST_UDF]   = udf_q;
    end

    always_comb begin
        dat_d = '0;
        if (rd) begin
            case (off)
                REG_STATUS: dat_d = status;
                REG_DATA:   dat_d[ENTRY_W-1:0] = head;
`ifdef ALU_RESULT_TIMESTAMP_EN
                REG_TSNOW:  dat_d[15:0] = ts_q;
`endif
                default:    dat_d = '0;
            endcase
        end
    end

    // A same-cycle overflow wins over a clear so the newer event stays visible.
    assign ovf_d = (ovf_q && !clr) || (push && full && !pop && !flush);
    assign udf_d = (udf_q && !clr) || (pop && empty);
    assign ack_d = req;
    assign irq_d = (count >= THRESH);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            irq_q <= irq_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_alu_result_collector;

    localparam int          DEPTH  = 8;
    localparam int          THRESH = 4;
    localparam logic [31:0] BASE   = 32'h3000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cap = 1'b0;
    logic [1:0]  active = 2'b00;
    logic [3:0]  o1 = '0, o2 = '0, x = '0;
    logic        c1 = 1'b0, c2 = 1'b0, y = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack, irq;
    logic [31:0] rdat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_collector #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .IRQ_THRESH(THRESH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .cap_i      (cap),
        .active_i   (active),
        .alu_out1_i (o1),
        .alu_out2_i (o2),
        .carry1_i   (c1),
        .carry2_i   (c2),
        .x_i        (x),
        .y_i        (y),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .irq_o      (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, registered outputs as plain variables.
    logic [31:0] mq[$];
    logic        m_ovf, m_udf, m_ack, m_irq;
    logic [31:0] m_dat;
    logic [15:0] m_ts;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_ack = 1'b0; m_irq = 1'b0;
            m_dat = '0;   m_ts = '0;
        end else begin : step
            int          n;
            logic        req, pop, wctl;
            logic [31:0] ent, rv;
            n    = mq.size();
            req  = stb && cyc && (adr[31:4] == BASE[31:4]) && !m_ack;
            pop  = req && !we && (adr[3:2] == 2'd1);
            wctl = req && we && (adr[3:2] == 2'd2) && sel[0];
            ent  = {17'b0, y, x, c2, c1, o2, o1};
`ifdef ALU_RESULT_TIMESTAMP_EN
            ent[31:16] = m_ts;
`endif
            rv = '0;
            if (req && !we) begin
                case (adr[3:2])
                    2'd0: rv = {20'b0, m_udf, m_ovf, (n == DEPTH), (n == 0), 2'b00, 6'(n)};
                    2'd1: rv = (n > 0) ? mq[0] : 32'h0;
`ifdef ALU_RESULT_TIMESTAMP_EN
                    2'd3: rv = {16'h0, m_ts};
`endif
                    default: rv = '0;
                endcase
            end
            m_irq = (n >= THRESH);
            if (pop && n == 0) m_udf = 1'b1;
            if (wctl && wdat[0]) begin m_ovf = 1'b0; m_udf = 1'b0; end
            if (wctl && wdat[1]) mq.delete();
            else begin
                if (pop && n > 0) void'(mq.pop_front());
                if (cap && active == 2'b00) begin
                    if (mq.size() < DEPTH) mq.push_back(ent);
                    else m_ovf = 1'b1;
                end
            end
            m_ack = req;
            m_dat = rv;
            m_ts  = m_ts + 16'd1;
        end
    end

    always @(negedge clk) begin
        check("ack", {31'b0, ack}, {31'b0, m_ack});
        check("rdata", rdat, m_dat);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    end

    task automatic drive_cap(input logic [14:0] e, input logic [1:0] act);
        cap = 1'b1;
        active = act;
        {y, x, c2, c1, o2, o1} = e;
    endtask

    task automatic capture(input logic [14:0] e);
        @(negedge clk);
        drive_cap(e, 2'b00);
        @(negedge clk);
        cap = 1'b0;
    endtask

    // One bus transfer, optionally with a capture on the request cycle.
    task automatic wb_xfer(input logic w, input logic [1:0] off, input logic [31:0] wd,
                           input logic with_cap, input logic [14:0] ce, output logic [31:0] d);
        logic got;
        got = 1'b0;
        d = '0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; sel = 4'hF; wdat = wd;
        adr = BASE | {28'h0, off, 2'b00};
        if (with_cap) drive_cap(ce, 2'b00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cap = 1'b0;
            if (ack) begin
                d = rdat;
                got = 1'b1;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 6 cycles");
        end
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        wb_xfer(1'b0, off, 32'h0, 1'b0, 15'h0, d);
    endtask

    task automatic wr_ctrl(input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, 2'd2, wd, 1'b0, 15'h0, dummy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d1, d2;
        logic        busy, match;
        int          wcnt;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        rd(2'd0, d);  check("reset_status", d, 32'h0000_0100);
        check("reset_irq", {31'b0, irq}, 32'h0);

        capture(15'h1234); capture(15'h0ABC); capture(15'h7FFF);
        rd(2'd0, d);  check("status_3", d, 32'h0000_0003);
        rd(2'd1, d);  check("data_0", d, 32'h0000_1234);
        rd(2'd1, d);  check("data_1", d, 32'h0000_0ABC);
        rd(2'd1, d);  check("data_2", d, 32'h0000_7FFF);
        rd(2'd0, d);  check("status_empty", d, 32'h0000_0100);

        @(negedge clk); drive_cap(15'h0055, 2'b01);
        repeat (5) @(negedge clk);
        cap = 1'b0; active = 2'b00;
        rd(2'd0, d);  check("inactive_status", d, 32'h0000_0100);
        check("inactive_irq", {31'b0, irq}, 32'h0);

        for (int i = 0; i < DEPTH + 2; i++) capture(15'h100 + 15'(i));
        rd(2'd0, d);  check("full_ovf_status", d, 32'h0000_0608);
        check("full_irq", {31'b0, irq}, 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(2'd1, d); check("drain", d, 32'h100 + 32'(i));
        end
        rd(2'd0, d);  check("ovf_sticky", d, 32'h0000_0500);
        wr_ctrl(32'h1);
        rd(2'd0, d);  check("ovf_cleared", d, 32'h0000_0100);

        rd(2'd1, d);  check("empty_read", d, 32'h0);
        rd(2'd0, d);  check("udf_status", d, 32'h0000_0900);
        wr_ctrl(32'h1);

        @(negedge clk); drive_cap(15'h0011, 2'b00);
        repeat (4) @(negedge clk);
        cap = 1'b0;
        check("irq_before", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise", {31'b0, irq}, 32'h1);
        for (int i = 0; i < 4; i++) capture(15'h21 + 15'(i));
        wb_xfer(1'b0, 2'd1, 32'h0, 1'b1, 15'h0055, d);
        check("pop_push_data", d, 32'h0000_0011);
        rd(2'd0, d);  check("pop_push_full", d, 32'h0000_0208);
        wb_xfer(1'b1, 2'd2, 32'h2, 1'b1, 15'h0066, d);
        rd(2'd0, d);  check("flush_push", d, 32'h0000_0100);

        for (int i = 0; i < 5; i++) capture(15'h40 + 15'(i));
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE | 32'h4;
        #2 rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_ack", {31'b0, ack}, 32'h0);
            check("rst_dat", rdat, 32'h0);
            check("rst_irq", {31'b0, irq}, 32'h0);
        end
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;

        @(negedge clk); drive_cap(15'h0001, 2'b00);
        @(negedge clk); cap = 1'b0;
        repeat (14) @(negedge clk);
        drive_cap(15'h0002, 2'b00);
        @(negedge clk); cap = 1'b0;
        rd(2'd1, d1); rd(2'd1, d2);
        check("ts_lo0", {16'h0, d1[15:0]}, 32'h1);
        check("ts_lo1", {16'h0, d2[15:0]}, 32'h2);
`ifdef ALU_RESULT_TIMESTAMP_EN
        check("ts_delta", {16'h0, d2[31:16] - d1[31:16]}, 32'd15);
`else
        check("ts_hi_zero", {d1[31:16], d2[31:16]}, 32'h0);
        rd(2'd3, d);  check("reg_c_zero", d, 32'h0);
`endif
        rd(2'd0, d);  check("post_reset_status", d, 32'h0000_0100);

        busy = 1'b0; match = 1'b0; wcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            cap    = ($urandom_range(0, 99) < 40);
            active = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            {y, x, c2, c1, o2, o1} = 15'($urandom);
            if (busy) begin
                wcnt++;
                if (ack) begin
                    busy = 1'b0; stb = 1'b0; cyc = 1'b0;
                end else if (wcnt > 2) begin
                    busy = 1'b0; stb = 1'b0; cyc = 1'b0;
                    if (match) begin
                        checks++; errors++;
                        $display("FAIL rand_ack_timeout: got no ack expected ack at %0t", $time);
                    end
                end
            end else if ($urandom_range(0, 99) < 35) begin
                match = ($urandom_range(0, 9) != 0);
                adr   = (match ? BASE : BASE + 32'h10) | {28'h0, 2'($urandom), 2'($urandom)};
                we    = ($urandom_range(0, 3) == 0);
                wdat  = {30'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom)};
                sel   = 4'($urandom);
                stb   = 1'b1; cyc = 1'b1; busy = 1'b1; wcnt = 0;
            end
        end
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; cap = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
